// File: rtl/command_decoder_if.sv
// Byte-stream input and decoded-command output channel of the command decoder.
// master = byte source / command consumer, slave = decoder.
interface command_decoder_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       cmd_ack;
   logic       ValidSignal;
   logic [7:0] AmountSignal;
   logic       onSignal;
   logic       offSignal;
   logic       increaseSignal;
   logic       decreaseSignal;

   modport master (
      output rx_data, rx_valid, cmd_ack,
      input  rx_ready, ValidSignal, AmountSignal,
      input  onSignal, offSignal, increaseSignal, decreaseSignal
   );

   modport slave (
      input  rx_data, rx_valid, cmd_ack,
      output rx_ready, ValidSignal, AmountSignal,
      output onSignal, offSignal, increaseSignal, decreaseSignal
   );
endinterface

// File: rtl/command_decoder.sv
// Framed command decoder: HEADER, OPCODE, AMOUNT[, CHK] -> held command until cmd_ack.
// Optional checksum byte enabled by defining CMD_DECODER_CHECKSUM_EN.
//
// state    | meaning
// HUNT     | discard bytes until HEADER
// OPCODE   | expect opcode byte, upper nibble must be zero
// AMOUNT   | expect amount byte
// CHECK    | expect HEADER^OPCODE^AMOUNT (checksum build only)
// HOLD     | command presented, wait for cmd_ack
module command_decoder #(
   parameter int           TIMEOUT_CYCLES = 1000,
   parameter logic [7:0]   HEADER         = 8'hA5
) (
   input  logic               clk,
   input  logic               rst,
   command_decoder_if.slave   bus,
   output logic               frame_error,
   output logic [7:0]         err_count
);

   localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_HUNT   = 3'd0,
      S_OPCODE = 3'd1,
      S_AMOUNT = 3'd2,
`ifdef CMD_DECODER_CHECKSUM_EN
      S_CHECK  = 3'd3,
`endif
      S_HOLD   = 3'd4
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             in_frame;
   logic             err_evt;
   logic             op_ld;
   logic             amt_ld;
   logic [TMR_W-1:0] tmr;
   logic             tmr_zero;
   logic [3:0]       op_q;
   logic [7:0]       amt_q;
   logic             hold;

   assign accept   = bus.rx_valid && bus.rx_ready;
   assign tmr_zero = (tmr == '0);
   assign hold     = (state == S_HOLD);
   assign in_frame = (state != S_HUNT) && (state != S_HOLD);

`ifdef CMD_DECODER_CHECKSUM_EN
   logic [7:0] chk;
   assign chk = HEADER ^ {4'd0, op_q} ^ amt_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_HUNT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      err_evt   = 1'b0;
      op_ld     = 1'b0;
      amt_ld    = 1'b0;
      case (state)
         S_HUNT: begin
            if (accept && (bus.rx_data == HEADER)) begin
               state_nxt = S_OPCODE;
            end
         end
         S_OPCODE: begin
            if (accept) begin
               if (bus.rx_data[7:4] != 4'd0) begin
                  err_evt   = 1'b1;
                  state_nxt = S_HUNT;
               end else begin
                  op_ld     = 1'b1;
                  state_nxt = S_AMOUNT;
               end
            end else if (tmr_zero) begin
               err_evt   = 1'b1;
               state_nxt = S_HUNT;
            end
         end
         S_AMOUNT: begin
            if (accept) begin
               amt_ld    = 1'b1;
`ifdef CMD_DECODER_CHECKSUM_EN
               state_nxt = S_CHECK;
`else
               state_nxt = S_HOLD;
`endif
            end else if (tmr_zero) begin
               err_evt   = 1'b1;
               state_nxt = S_HUNT;
            end
         end
`ifdef CMD_DECODER_CHECKSUM_EN
         S_CHECK: begin
            if (accept) begin
               if (bus.rx_data == chk) begin
                  state_nxt = S_HOLD;
               end else begin
                  err_evt   = 1'b1;
                  state_nxt = S_HUNT;
               end
            end else if (tmr_zero) begin
               err_evt   = 1'b1;
               state_nxt = S_HUNT;
            end
         end
`endif
         S_HOLD: begin
            if (bus.cmd_ack) begin
               state_nxt = S_HUNT;
            end
         end
         default: begin
            state_nxt = S_HUNT;
         end
      endcase
   end

   always_comb begin
      bus.rx_ready       = !hold;
      bus.ValidSignal    = hold;
      bus.AmountSignal   = hold ? amt_q : 8'd0;
      bus.onSignal       = hold && op_q[0];
      bus.offSignal      = hold && op_q[1];
      bus.increaseSignal = hold && op_q[2];
      bus.decreaseSignal = hold && op_q[3];
   end

   // Reload on every accepted byte; timeout fires on the TIMEOUT_CYCLES-th idle cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmr <= '0;
      end else if (accept) begin
         tmr <= TMR_LOAD;
      end else if (!in_frame) begin
         tmr <= '0;
      end else if (!tmr_zero) begin
         tmr <= tmr - TMR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q  <= 4'd0;
         amt_q <= 8'd0;
      end else begin
         if (op_ld) begin
            op_q <= bus.rx_data[3:0];
         end
         if (amt_ld) begin
            amt_q <= bus.rx_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_error <= 1'b0;
         err_count   <= 8'd0;
      end else begin
         frame_error <= err_evt;
         if (err_evt && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_command_decoder.sv
// Bench for command_decoder: directed frames plus randomized frame mix against a frame-level model.
module tb_command_decoder;
   localparam int         TO  = 1000;
   localparam logic [7:0] HDR = 8'hA5;

   logic       clk = 1'b0;
   logic       rst;
   logic       frame_error;
   logic [7:0] err_count;

   command_decoder_if bus ();

   command_decoder #(.TIMEOUT_CYCLES(TO), .HEADER(HDR)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .frame_error (frame_error),
      .err_count   (err_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int err_high = 0;
   int model_pulses = 0;
   int model_err    = 0;

   always @(negedge clk) begin
      if (frame_error === 1'b1) err_high <= err_high + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [3:0] flags();
      return {bus.decreaseSignal, bus.increaseSignal, bus.offSignal, bus.onSignal};
   endfunction

   task automatic model_error();
      model_pulses++;
      if (model_err < 255) model_err++;
   endtask

   task automatic check_errs(input string tag);
      #1;
      check({tag, "_pulses"}, err_high, model_pulses);
      check({tag, "_errcnt"}, {24'd0, err_count}, model_err);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid0"}, {31'd0, bus.ValidSignal}, 0);
      check({tag, "_cmd0"}, {20'd0, flags(), bus.AmountSignal}, 0);
      check({tag, "_ready1"}, {31'd0, bus.rx_ready}, 1);
   endtask

   task automatic send_byte(input logic [7:0] b, input int extra, input bit ack);
      repeat (extra) @(negedge clk);
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      bus.cmd_ack  = ack;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.cmd_ack  = 1'b0;
      bus.rx_data  = 8'($urandom);
   endtask

   function automatic logic [7:0] csum(input logic [7:0] op, input logic [7:0] amt);
      return HDR ^ op ^ amt;
   endfunction

   task automatic send_frame(input logic [7:0] op, input logic [7:0] amt,
                             input logic [7:0] chk, input int gap, input bit ack);
      send_byte(HDR, gap, ack);
      send_byte(op, gap, ack);
      send_byte(amt, gap, ack);
`ifdef CMD_DECODER_CHECKSUM_EN
      send_byte(chk, gap, ack);
`else
      if (chk == 8'h00) ;
`endif
   endtask

   // Called right after the final byte's handshake; consumes the command.
   task automatic expect_cmd(input string tag, input logic [3:0] op, input logic [7:0] amt, input int hold_cyc);
      check({tag, "_valid"}, {31'd0, bus.ValidSignal}, 1);
      check({tag, "_ready0"}, {31'd0, bus.rx_ready}, 0);
      check({tag, "_cmd"}, {20'd0, flags(), bus.AmountSignal}, {20'd0, op, amt});
      repeat (hold_cyc) @(negedge clk);
      check({tag, "_held"}, {19'd0, bus.ValidSignal, flags(), bus.AmountSignal}, {19'd0, 1'b1, op, amt});
      bus.cmd_ack = 1'b1;
      @(negedge clk);
      bus.cmd_ack = 1'b0;
      check_idle({tag, "_ack"});
   endtask

   initial begin
      logic [7:0] op, amt, junk, chk;
      int kind;
      bus.rx_data  = 8'd0;
      bus.rx_valid = 1'b0;
      bus.cmd_ack  = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ferr", {31'd0, frame_error}, 0);
      rst = 1'b0;
      check_idle("rst");
      check_errs("rst");

      // Basic frame: on + increase, amount 0x20
      send_frame(8'h05, 8'h20, csum(8'h05, 8'h20), 0, 1'b0);
      expect_cmd("basic", 4'h5, 8'h20, 7);
      check_errs("basic");

`ifdef CMD_DECODER_CHECKSUM_EN
      send_frame(8'h09, 8'h10, 8'h00, 0, 1'b0);
      model_error();
      check_idle("badchk");
      check_errs("badchk");
`endif
      send_frame(8'h02, 8'h00, csum(8'h02, 8'h00), 0, 1'b0);
      expect_cmd("off", 4'h2, 8'h00, 1);

      // Junk byte discarded, then bad opcode
      send_byte(8'h33, 0, 1'b0);
      check_errs("junk");
      send_byte(HDR, 0, 1'b0);
      send_byte(8'h15, 0, 1'b0);
      model_error();
      check_errs("badop");
      // HEADER as opcode is rejected, not resynchronized
      send_byte(HDR, 0, 1'b0);
      send_byte(HDR, 0, 1'b0);
      model_error();
      check_errs("hdr_op");

      // Timeout: no error after TO-1 idle cycles, error on the TO-th
      send_byte(HDR, 0, 1'b0);
      send_byte(8'h05, 0, 1'b0);
      repeat (TO - 1) @(negedge clk);
      check_errs("to_early");
      @(negedge clk);
      model_error();
      check_errs("to_fire");
      send_byte(8'h20, 0, 1'b0);
      send_byte(8'h40, 0, 1'b0);
      check_idle("to_hunt");
      check_errs("to_hunt");

      // Gaps of TO-1 idle cycles between bytes are tolerated
      send_frame(8'h0A, 8'h7E, csum(8'h0A, 8'h7E), TO - 2, 1'b0);
      expect_cmd("gap_max", 4'hA, 8'h7E, 0);
      check_errs("gap_max");

      repeat (5000) @(negedge clk);
      check_errs("hunt_idle");

      // Randomized frame mix
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(2) == 0) begin
            junk = 8'($urandom);
            if (junk == HDR) junk = 8'h00;
            send_byte(junk, $urandom_range(3), 1'($urandom));
         end
         kind = $urandom_range(3);
         op   = {4'd0, 4'($urandom)};
         amt  = 8'($urandom);
         chk  = csum(op, amt);
`ifndef CMD_DECODER_CHECKSUM_EN
         if (kind == 3) kind = 0;
`endif
         if (kind == 2) begin
            op = ($urandom_range(4) == 0) ? HDR : {4'($urandom_range(15, 1)), 4'($urandom)};
            send_byte(HDR, $urandom_range(3), 1'($urandom));
            send_byte(op, $urandom_range(3), 1'($urandom));
            model_error();
            check_idle("rnd_badop");
         end else if (kind == 3) begin
            send_frame(op, amt, chk ^ 8'($urandom_range(255, 1)), $urandom_range(2), 1'($urandom));
            model_error();
            check_idle("rnd_badchk");
         end else begin
            send_frame(op, amt, chk, $urandom_range(2), 1'($urandom));
            expect_cmd("rnd_good", op[3:0], amt, $urandom_range(4));
         end
         check_errs("rnd");
      end

      // Saturation
      for (int n = 0; n < 300; n++) begin
         send_byte(HDR, 0, 1'b0);
         send_byte({4'($urandom_range(15, 1)), 4'($urandom)}, 0, 1'b0);
         model_error();
      end
      check_errs("sat");
      check("sat_255", {24'd0, err_count}, 32'd255);

      // Reset while holding a command
      send_frame(8'h04, 8'h11, csum(8'h04, 8'h11), 0, 1'b0);
      check("pre_rst_valid", {31'd0, bus.ValidSignal}, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_err = 0;
      check_idle("rst_hold");
      check_errs("rst_hold");

      // Reset mid-frame discards the partial frame silently
      send_byte(HDR, 0, 1'b0);
      send_byte(8'h05, 0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_errs("rst_mid");
      send_frame(8'h0C, 8'h99, csum(8'h0C, 8'h99), 0, 1'b0);
      expect_cmd("post_rst", 4'hC, 8'h99, 2);
      check_errs("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/command_decoder.md
COMMAND_DECODER -- requirements
Module: command_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000: max idle cycles between bytes inside a frame.
REQ-002 SHALL have parameter HEADER, default 8'hA5: frame start byte.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 rx_data  in  8  incoming command byte.
REQ-006 rx_valid  in  1  rx_data valid; byte accepted when rx_valid && rx_ready.
REQ-007 rx_ready  out  1  decoder can accept a byte.
REQ-008 cmd_ack  in  1  consumer took the current command (1-cycle pulse).
REQ-009 ValidSignal  out  1  decoded command present and stable.
REQ-010 AmountSignal  out  8  step amount.
REQ-011 onSignal, offSignal, increaseSignal, decreaseSignal  out  1 each  opcode bits 0..3.
REQ-012 frame_error  out  1  one-cycle pulse on any rejected frame.
REQ-013 err_count  out  8  saturating count of rejected frames.

Function
REQ-014 Frame SHALL be HEADER, OPCODE, AMOUNT[, CHK]; CHK = HEADER ^ OPCODE ^ AMOUNT.
REQ-015 FSM states SHALL be HUNT, OPCODE, AMOUNT, CHECK, HOLD; one byte consumed per accepted handshake.
REQ-016 HUNT: byte == HEADER -> OPCODE; any other byte silently discarded, no error.
REQ-017 OPCODE: bits[7:4] != 0 -> error, HUNT; else latch bits[3:0] -> AMOUNT.
REQ-018 AMOUNT: latch byte -> CHECK (CHECKSUM_EN) or HOLD.
REQ-019 CHECK: byte == computed CHK -> HOLD; mismatch -> error, HUNT.
REQ-020 ValidSignal SHALL rise the cycle after the final byte's handshake (latency 1).
REQ-021 HOLD: rx_ready = 0; all command outputs stable; cmd_ack -> ValidSignal low next cycle, -> HUNT.
REQ-022 rx_ready SHALL be 1 in HUNT, OPCODE, AMOUNT, CHECK.
REQ-023 Command outputs SHALL be 0 whenever ValidSignal is 0.
REQ-024 Opcode bits passed through unmodified; conflicting combos (on+off, inc+dec) SHALL NOT be filtered.
REQ-025 Timeout counter SHALL reset on every accepted byte; in OPCODE/AMOUNT/CHECK, reaching TIMEOUT_CYCLES cycles without a byte -> error, HUNT.
REQ-026 Timeout SHALL NOT run in HUNT or HOLD.
REQ-027 Error = frame_error high 1 cycle; err_count +1, saturating at 255.
REQ-028 cmd_ack outside HOLD SHALL be ignored.
REQ-029 HEADER byte inside OPCODE is a bad opcode (error); no resynchronization mid-frame.

Reset
REQ-030 rst SHALL force state HUNT, rx_ready 1, ValidSignal 0, all command outputs 0, frame_error 0, err_count 0, timeout counter 0.
REQ-031 rst mid-frame or in HOLD SHALL discard the partial or pending command without asserting frame_error.

Configuration
REQ-032 Macro CMD_DECODER_CHECKSUM_EN: defined -> 4-byte frames, CHECK state present, REQ-019 applies.
REQ-033 Undefined -> 3-byte frames, CHECK state absent, AMOUNT goes directly to HOLD, no checksum logic.

Verification
REQ-034 CHECKSUM_EN: bytes A5,05,20,80 -> ValidSignal 1 one cycle after last byte; onSignal=1, increaseSignal=1, AmountSignal=0x20; holds until cmd_ack.
REQ-035 CHECKSUM_EN: A5,09,10,00 (expected BC) -> frame_error pulse, err_count=1, ValidSignal stays 0, next frame A5,02,00,A7 decodes offSignal=1.
REQ-036 Bytes 33,A5,15 -> 33 discarded silently, 15 rejected as bad opcode, err_count=1.
REQ-037 A5,05 then idle 1000 cycles -> frame_error on timeout, state HUNT; idle in HUNT 5000 cycles -> no error.
REQ-038 300 bad frames -> err_count saturates at 255; rst in HOLD -> ValidSignal 0 next cycle, err_count 0.
